csr_hpm: RTL and testbench
==========================

CSR_HPM -- requirements
Module: csr_hpm

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning CSR data width; legal values are 32 and 64.
REQ-002 SHALL have parameter NUM_HPM, default 4, meaning the number of mhpmcounter/mhpmevent pairs; legal range is 0..29.
REQ-003 SHALL have parameter EVENT_W, default 8, meaning the number of event input lines.
REQ-004 SHALL have port clock, input, 1, meaning the rising-edge clock.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port wen, input, 1, meaning CSR write strobe.
REQ-007 SHALL have port addr, input, 12, meaning CSR address for read and write.
REQ-008 SHALL have port wdata, input, XLEN, meaning CSR write data.
REQ-009 SHALL have port inst_retire, input, 1, meaning one instruction retired this cycle.
REQ-010 SHALL have port events, input, EVENT_W, meaning per-cycle event pulses.
REQ-011 SHALL have port rdata, output, XLEN, meaning the combinational read of the CSR at addr.
REQ-012 SHALL have port illegal, output, 1, meaning combinational flag for an unimplemented address or a wen to a read-only address.
REQ-013 SHALL have port ovf, output, NUM_HPM+3, meaning one-cycle counter-wrap pulses; bit index equals counter index, and bit 1 is always 0.

Function
REQ-014 SHALL hold 64-bit counters mcycle (index 0), minstret (index 2) and hpm[i] (index 3+i).
REQ-015 SHALL hold registers mhpmevent[i] (EVENT_W bits) and mcountinhibit (NUM_HPM+3 bits); mcountinhibit bit 1 is hardwired 0.
REQ-016 SHALL map the machine registers as follows: mcycle 0xB00, minstret 0xB02, hpm[i] 0xB03+i, mcountinhibit 0x320, mhpmevent[i] 0x323+i.
REQ-017 SHALL, when XLEN=32, map the high counter halves at 0xB80, 0xB82 and 0xB83+i; when XLEN=64 those addresses are unimplemented.
REQ-018 SHALL provide read-only user shadows: cycle 0xC00, instret 0xC02, hpmcounter 0xC03+i, and when XLEN=32 the high halves at 0xC80, 0xC82 and 0xC83+i.
REQ-019 SHALL return constant reads: misa 0x301 = 0x40001000 for XLEN=32 or {2'b10, 0...0, bit12 set} for XLEN=64, mvendorid 0xF11 = "beka", marchid 0xF12 = 0x05318008.
REQ-020 SHALL return 0 on rdata and assert illegal for any unimplemented address, including hpm indices at or above NUM_HPM.
REQ-021 SHALL zero-extend mhpmevent and mcountinhibit on read.
REQ-022 SHALL show on rdata the pre-edge register value, with no write-through.
REQ-023 SHALL increment mcycle by 1 each cycle when inhibit[0]=0.
REQ-024 SHALL increment minstret by 1 when inst_retire=1 and inhibit[2]=0.
REQ-025 SHALL increment hpm[i] by 1 when |(events & mhpmevent[i]) is 1 and inhibit[3+i]=0; multiple matching events in one cycle still add 1.
REQ-026 SHALL let a CSR write to either half of a counter win over increment for that whole counter that cycle: the written half takes wdata and the other half holds.
REQ-027 SHALL apply a write with illegal=1 as a no-op, including writes to shadow and constant addresses.
REQ-028 SHALL wrap counters modulo 2^64.
REQ-029 SHALL, when an increment takes a counter from all-ones to 0, set ovf[idx] in the next cycle for exactly one cycle; a write to zero never sets ovf.
REQ-030 SHALL, on a write to mcountinhibit, apply the new inhibit from the next cycle, so the write cycle still counts under the old value.
REQ-031 SHALL give counters other than the one being written their normal increment in a write cycle.

Reset
REQ-032 SHALL, while reset is asserted, asynchronously clear all counters, mhpmevent, mcountinhibit and ovf to 0.
REQ-033 SHALL resume counting on the first rising edge after reset deasserts, so mcycle reads 1 one cycle after release.
REQ-034 SHALL, on reset mid-operation, discard any in-flight ovf pulse and any pending write.

Verification
REQ-035 SHALL cover: release reset, idle 10 cycles -> mcycle=10, minstret=0, all hpm=0, ovf=0.
REQ-036 SHALL cover: XLEN=32, write 0xB80=0x1 then 0xB00=0xFFFFFFFE -> the 64-bit mcycle reads 0x1_FFFFFFFE and becomes 0x1_FFFFFFFF one cycle later; the write cycle itself does not increment.
REQ-037 SHALL cover: write minstret to 0xFFFFFFFF_FFFFFFFF, inst_retire=1 for one cycle -> minstret=0 and ovf[2]=1 for exactly one cycle.
REQ-038 SHALL cover: mhpmevent[1]=0x05 with events=0x04 for 3 cycles, then events=0x02 for 2 cycles -> hpm[1]=3; then events=0x05 for 1 cycle -> hpm[1]=4.
REQ-039 SHALL cover: write mcountinhibit=0x01 -> mcycle advances 1 more cycle, then freezes; write 0x00 -> counting resumes.
REQ-040 SHALL cover: write 0xC00 = 0x1234 and read 0x7C0 -> illegal=1, rdata=0, no state change; read 0xB07 with NUM_HPM=4 -> illegal=1.

Source files
------------

// File: rtl/csr_hpm.sv
// Machine-mode hardware performance monitor CSR block: mcycle, minstret, mhpmcounters,
// their event selectors, mcountinhibit, user read-only shadows and identity constants.
module csr_hpm #(
    parameter int XLEN    = 32,
    parameter int NUM_HPM = 4,
    parameter int EVENT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wen,
    input  logic [11:0]          addr,
    input  logic [XLEN-1:0]      wdata,
    input  logic                 inst_retire,
    input  logic [EVENT_W-1:0]   events,
    output logic [XLEN-1:0]      rdata,
    output logic                 illegal,
    output logic [NUM_HPM+2:0]   ovf
);

    localparam int NCNT = NUM_HPM + 3;
    localparam int NEVT = (NUM_HPM > 0) ? NUM_HPM : 1;

    localparam logic [63:0] MISA_VAL  = (XLEN == 32) ? 64'h0000_0000_4000_1000
                                                     : 64'h8000_0000_0000_1000;
    localparam logic [63:0] MVENDORID = 64'h0000_0000_6265_6B61;
    localparam logic [63:0] MARCHID   = 64'h0000_0000_0531_8008;

    logic [63:0]        cnt_q [NCNT];
    logic [63:0]        cnt_d [NCNT];
    logic [EVENT_W-1:0] evt_q [NEVT];
    logic [EVENT_W-1:0] evt_d [NEVT];
    logic [NCNT-1:0]    inh_q, inh_d;
    logic [NCNT-1:0]    ovf_q, ovf_d;

    logic [63:0]        wdata64;
    logic [XLEN-1:0]    rd_val;
    logic               impl;
    logic               ro;
    logic               we;
    logic [NCNT-1:0]    sel_lo;
    logic [NCNT-1:0]    sel_hi;
    logic [NCNT-1:0]    inc;
    logic               sel_inh;
    logic [NEVT-1:0]    sel_evt;

    assign wdata64 = 64'(wdata);

    // Address decode and read mux; index 1 (the unimplemented mtime slot) never decodes.
    always_comb begin
        impl    = 1'b0;
        ro      = 1'b0;
        rd_val  = '0;
        sel_lo  = '0;
        sel_hi  = '0;
        sel_inh = 1'b0;
        sel_evt = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (k != 1) begin
                if (addr == 12'(32'hB00 + k)) begin
                    impl      = 1'b1;
                    sel_lo[k] = 1'b1;
                    rd_val    = XLEN'(cnt_q[k]);
                end
                if (XLEN == 32 && addr == 12'(32'hB80 + k)) begin
                    impl      = 1'b1;
                    sel_hi[k] = 1'b1;
                    rd_val    = XLEN'(cnt_q[k][63:32]);
                end
                if (addr == 12'(32'hC00 + k)) begin
                    impl   = 1'b1;
                    ro     = 1'b1;
                    rd_val = XLEN'(cnt_q[k]);
                end
                if (XLEN == 32 && addr == 12'(32'hC80 + k)) begin
                    impl   = 1'b1;
                    ro     = 1'b1;
                    rd_val = XLEN'(cnt_q[k][63:32]);
                end
            end
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (addr == 12'(32'h323 + i)) begin
                impl       = 1'b1;
                sel_evt[i] = 1'b1;
                rd_val     = XLEN'(evt_q[i]);
            end
        end
        case (addr)
            12'h320: begin
                impl    = 1'b1;
                sel_inh = 1'b1;
                rd_val  = XLEN'(inh_q);
            end
            12'h301: begin
                impl   = 1'b1;
                ro     = 1'b1;
                rd_val = XLEN'(MISA_VAL);
            end
            12'hF11: begin
                impl   = 1'b1;
                ro     = 1'b1;
                rd_val = XLEN'(MVENDORID);
            end
            12'hF12: begin
                impl   = 1'b1;
                ro     = 1'b1;
                rd_val = XLEN'(MARCHID);
            end
            default: ;
        endcase
    end

    assign illegal = !impl || (wen && ro);
    assign we      = wen && !illegal;
    assign rdata   = rd_val;
    assign ovf     = ovf_q;

    // Next state: a write to either half of a counter suppresses its increment and its wrap pulse.
    always_comb begin
        inc    = '0;
        inc[0] = !inh_q[0];
        inc[2] = inst_retire && !inh_q[2];
        for (int i = 0; i < NUM_HPM; i++) begin
            inc[3+i] = (|(events & evt_q[i])) && !inh_q[3+i];
        end

        ovf_d = '0;
        for (int k = 0; k < NCNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (we && sel_lo[k]) begin
                cnt_d[k] = (XLEN == 32) ? {cnt_q[k][63:32], wdata64[31:0]} : wdata64;
            end else if (we && sel_hi[k]) begin
                cnt_d[k] = {wdata64[31:0], cnt_q[k][31:0]};
            end else if (inc[k]) begin
                cnt_d[k] = cnt_q[k] + 64'd1;
                ovf_d[k] = &cnt_q[k];
            end
        end

        inh_d = inh_q;
        if (we && sel_inh) begin
            inh_d    = wdata64[NCNT-1:0];
            inh_d[1] = 1'b0;
        end

        for (int i = 0; i < NEVT; i++) begin
            evt_d[i] = evt_q[i];
            if (we && sel_evt[i]) begin
                evt_d[i] = wdata64[EVENT_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
            end
            for (int i = 0; i < NEVT; i++) begin
                evt_q[i] <= '0;
            end
            inh_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            for (int i = 0; i < NEVT; i++) begin
                evt_q[i] <= evt_d[i];
            end
            inh_q <= inh_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_csr_hpm.sv
// Bench for csr_hpm: directed scenarios plus randomized traffic against a behavioural CSR model.
`timescale 1ns/1ns
module tb_csr_hpm;

    localparam int XLEN    = 32;
    localparam int NUM_HPM = 4;
    localparam int EVENT_W = 8;
    localparam int NCNT    = NUM_HPM + 3;

    localparam int K_NONE = 0, K_LO = 1, K_HI = 2, K_SLO = 3, K_SHI = 4,
                   K_INH = 5, K_EVT = 6, K_MISA = 7, K_VEND = 8, K_ARCH = 9;

    logic                clock = 1'b0;
    logic                reset;
    logic                wen;
    logic [11:0]         addr;
    logic [XLEN-1:0]     wdata;
    logic                inst_retire;
    logic [EVENT_W-1:0]  events;
    logic [XLEN-1:0]     rdata;
    logic                illegal;
    logic [NUM_HPM+2:0]  ovf;

    int errors = 0;
    int checks = 0;

    logic [63:0]        m_cnt [NCNT];
    logic [EVENT_W-1:0] m_evt [NUM_HPM];
    logic [NCNT-1:0]    m_inh;
    logic [NCNT-1:0]    m_ovf;

    csr_hpm #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .EVENT_W(EVENT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .wen         (wen),
        .addr        (addr),
        .wdata       (wdata),
        .inst_retire (inst_retire),
        .events      (events),
        .rdata       (rdata),
        .illegal     (illegal),
        .ovf         (ovf)
    );

    always #50 clock = ~clock;

    task automatic model_reset();
        for (int k = 0; k < NCNT; k++) m_cnt[k] = '0;
        for (int i = 0; i < NUM_HPM; i++) m_evt[i] = '0;
        m_inh = '0;
        m_ovf = '0;
    endtask

    task automatic model_decode(input logic [11:0] a, output int kind, output int idx);
        int ia;
        ia   = int'(a);
        kind = K_NONE;
        idx  = 0;
        if (ia >= 'hB00 && ia < 'hB00 + NCNT && ia != 'hB01) begin kind = K_LO;  idx = ia - 'hB00; end
        if (ia >= 'hB80 && ia < 'hB80 + NCNT && ia != 'hB81) begin kind = K_HI;  idx = ia - 'hB80; end
        if (ia >= 'hC00 && ia < 'hC00 + NCNT && ia != 'hC01) begin kind = K_SLO; idx = ia - 'hC00; end
        if (ia >= 'hC80 && ia < 'hC80 + NCNT && ia != 'hC81) begin kind = K_SHI; idx = ia - 'hC80; end
        if (ia >= 'h323 && ia < 'h323 + NUM_HPM)              begin kind = K_EVT; idx = ia - 'h323; end
        if (ia == 'h320) kind = K_INH;
        if (ia == 'h301) kind = K_MISA;
        if (ia == 'hF11) kind = K_VEND;
        if (ia == 'hF12) kind = K_ARCH;
    endtask

    task automatic model_read(input logic w, input logic [11:0] a,
                              output logic [31:0] rd, output logic ill);
        int kind, idx;
        model_decode(a, kind, idx);
        case (kind)
            K_LO, K_SLO: rd = m_cnt[idx][31:0];
            K_HI, K_SHI: rd = m_cnt[idx][63:32];
            K_INH:       rd = 32'(m_inh);
            K_EVT:       rd = 32'(m_evt[idx]);
            K_MISA:      rd = 32'h4000_1000;
            K_VEND:      rd = 32'h6265_6B61;
            K_ARCH:      rd = 32'h0531_8008;
            default:     rd = 32'h0;
        endcase
        ill = (kind == K_NONE) ||
              (w && (kind == K_SLO || kind == K_SHI || kind == K_MISA ||
                     kind == K_VEND || kind == K_ARCH));
    endtask

    // Advances the model by one clock using the inputs currently on the pins.
    task automatic model_step();
        int kind, widx;
        logic ill, hit;
        logic [31:0] dummy;
        logic [NCNT-1:0] nov;
        model_decode(addr, kind, widx);
        model_read(wen, addr, dummy, ill);
        nov = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (k == 1) continue;
            if (wen && !ill && k == widx && (kind == K_LO || kind == K_HI)) begin
                if (kind == K_LO) m_cnt[k][31:0]  = wdata;
                else              m_cnt[k][63:32] = wdata;
            end else begin
                if (k == 0)      hit = 1'b1;
                else if (k == 2) hit = inst_retire;
                else             hit = ((events & m_evt[k-3]) != 0);
                if (hit && !m_inh[k]) begin
                    if (m_cnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) nov[k] = 1'b1;
                    m_cnt[k] = m_cnt[k] + 64'd1;
                end
            end
        end
        if (wen && !ill && kind == K_INH) m_inh = wdata[NCNT-1:0] & ~(NCNT'(2));
        if (wen && !ill && kind == K_EVT) m_evt[widx] = wdata[EVENT_W-1:0];
        m_ovf = nov;
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [11:0] a, input logic [31:0] d,
                         input logic ir, input logic [EVENT_W-1:0] ev);
        wen = w; addr = a; wdata = d; inst_retire = ir; events = ev;
        #1;
    endtask

    task automatic peek64(input int idx, output logic [63:0] v);
        wen  = 1'b0;
        addr = 12'('hB00 + idx);
        #1 v[31:0] = rdata;
        addr = 12'('hB80 + idx);
        #1 v[63:32] = rdata;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        wen = 1'b0; addr = '0; wdata = '0; inst_retire = 1'b0; events = '0;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        reset = 1'b1;
        wen = 1'b0; addr = '0; wdata = '0; inst_retire = 1'b0; events = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        peek64(0, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("FAIL reset_mcycle got=%h exp=0", v); end
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL reset_ovf got=%h exp=0", ovf); end
        reset = 1'b0;
        drive(0, 12'h000, 0, 0, 0);
        step();
        peek64(0, v);
        checks++;
        if (v !== 64'd1) begin errors++; $display("FAIL release_mcycle got=%h exp=1", v); end
    endtask

    task automatic test_idle();
        logic [63:0] v;
        apply_reset();
        drive(0, 12'h000, 0, 0, 0);
        repeat (10) step();
        peek64(0, v);
        checks++;
        if (v !== 64'd10) begin errors++; $display("FAIL idle_mcycle got=%h exp=10", v); end
        peek64(2, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL idle_minstret got=%h exp=0", v); end
        for (int i = 0; i < NUM_HPM; i++) begin
            peek64(3 + i, v);
            checks++;
            if (v !== 64'd0) begin errors++; $display("FAIL idle_hpm%0d got=%h exp=0", i, v); end
        end
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL idle_ovf got=%h exp=0", ovf); end
    endtask

    task automatic test_split_write();
        logic [63:0] v;
        drive(1, 12'hB80, 32'h1, 0, 0);
        step();
        drive(1, 12'hB00, 32'hFFFF_FFFE, 0, 0);
        step();
        peek64(0, v);
        checks++;
        if (v !== 64'h1_FFFF_FFFE) begin errors++; $display("FAIL split_write got=%h exp=1fffffffe", v); end
        drive(0, 12'h000, 0, 0, 0);
        step();
        peek64(0, v);
        checks++;
        if (v !== 64'h1_FFFF_FFFF) begin errors++; $display("FAIL split_next got=%h exp=1ffffffff", v); end
    endtask

    task automatic test_wrap_ovf();
        logic [63:0] v;
        drive(1, 12'hB02, 32'hFFFF_FFFF, 0, 0);
        step();
        drive(1, 12'hB82, 32'hFFFF_FFFF, 0, 0);
        step();
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL write_no_ovf got=%h exp=0", ovf); end
        drive(0, 12'h000, 0, 1, 0);
        step();
        peek64(2, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("FAIL wrap_minstret got=%h exp=0", v); end
        checks++;
        if (ovf !== 7'h04) begin errors++; $display("FAIL wrap_ovf got=%h exp=04", ovf); end
        drive(0, 12'h000, 0, 0, 0);
        step();
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL ovf_pulse_len got=%h exp=0", ovf); end
    endtask

    task automatic test_event_count();
        logic [63:0] v;
        apply_reset();
        drive(1, 12'h324, 32'h05, 0, 0);
        step();
        drive(0, 12'h000, 0, 0, 8'h04);
        repeat (3) step();
        drive(0, 12'h000, 0, 0, 8'h02);
        repeat (2) step();
        peek64(4, v);
        checks++;
        if (v !== 64'd3) begin errors++; $display("FAIL hpm1_count got=%h exp=3", v); end
        drive(0, 12'h000, 0, 0, 8'h05);
        step();
        peek64(4, v);
        checks++;
        if (v !== 64'd4) begin errors++; $display("FAIL hpm1_multi got=%h exp=4", v); end
        peek64(3, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL hpm0_unselected got=%h exp=0", v); end
    endtask

    task automatic test_inhibit();
        logic [63:0] v0, v;
        drive(0, 12'h000, 0, 0, 0);
        step();
        peek64(0, v0);
        drive(1, 12'h320, 32'h1, 0, 0);
        step();
        peek64(0, v);
        checks++;
        if (v !== v0 + 64'd1) begin errors++; $display("FAIL inhibit_write_cycle got=%h exp=%h", v, v0 + 64'd1); end
        drive(0, 12'h000, 0, 0, 0);
        repeat (3) step();
        peek64(0, v);
        checks++;
        if (v !== v0 + 64'd1) begin errors++; $display("FAIL inhibit_frozen got=%h exp=%h", v, v0 + 64'd1); end
        drive(1, 12'h320, 32'h0, 0, 0);
        step();
        drive(0, 12'h000, 0, 0, 0);
        step();
        peek64(0, v);
        checks++;
        if (v !== v0 + 64'd2) begin errors++; $display("FAIL inhibit_resume got=%h exp=%h", v, v0 + 64'd2); end
        drive(1, 12'h320, 32'hFFFF_FFFF, 0, 0);
        step();
        drive(0, 12'h320, 0, 0, 0);
        checks++;
        if (rdata !== 32'h7D) begin errors++; $display("FAIL inhibit_bit1 got=%h exp=0000007d", rdata); end
        drive(1, 12'h320, 32'h0, 0, 0);
        step();
    endtask

    task automatic test_illegal();
        logic [63:0] v;
        drive(1, 12'hC00, 32'h1234, 0, 0);
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL shadow_write_illegal got=%b exp=1", illegal); end
        step();
        peek64(0, v);
        checks++;
        if (v !== m_cnt[0]) begin errors++; $display("FAIL shadow_write_noop got=%h exp=%h", v, m_cnt[0]); end
        drive(0, 12'h7C0, 0, 0, 0);
        checks++;
        if (illegal !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL unimpl_7c0 got=%b/%h exp=1/0", illegal, rdata);
        end
        drive(0, 12'hB07, 0, 0, 0);
        checks++;
        if (illegal !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL unimpl_b07 got=%b/%h exp=1/0", illegal, rdata);
        end
        drive(0, 12'hF11, 0, 0, 0);
        checks++;
        if (rdata !== 32'h6265_6B61) begin errors++; $display("FAIL mvendorid got=%h exp=62656b61", rdata); end
        drive(0, 12'h301, 0, 0, 0);
        checks++;
        if (rdata !== 32'h4000_1000 || illegal !== 1'b0) begin
            errors++; $display("FAIL misa got=%h/%b exp=40001000/0", rdata, illegal);
        end
        drive(1, 12'h301, 32'h0, 0, 0);
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL misa_write got=%b exp=1", illegal); end
        step();
    endtask

    task automatic test_reset_midop();
        logic [63:0] v;
        drive(1, 12'hB02, 32'hFFFF_FFFF, 0, 0);
        step();
        drive(1, 12'hB82, 32'hFFFF_FFFF, 0, 0);
        step();
        drive(0, 12'h000, 0, 1, 0);
        step();
        checks++;
        if (ovf !== 7'h04) begin errors++; $display("FAIL midop_ovf_set got=%h exp=04", ovf); end
        drive(1, 12'hB00, 32'h55, 0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL midop_ovf_cleared got=%h exp=0", ovf); end
        peek64(0, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("FAIL midop_async_clear got=%h exp=0", v); end
        wen = 1'b1; addr = 12'hB00; wdata = 32'h55;
        @(posedge clock);
        #1;
        drive(0, 12'h000, 0, 0, 0);
        reset = 1'b0;
        step();
        peek64(0, v);
        checks++;
        if (v !== 64'd1) begin errors++; $display("FAIL midop_write_dropped got=%h exp=1", v); end
    endtask

    task automatic test_random();
        logic [11:0] alist [28];
        logic [11:0] a;
        logic [31:0] d, erd;
        logic        w, eill;
        logic [63:0] v;
        alist = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB80, 12'hB82,
                  12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hC00, 12'hC02, 12'hC83, 12'hC86,
                  12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'h301, 12'hF11, 12'hF12,
                  12'h7C0, 12'hB01, 12'hB07, 12'h327};
        apply_reset();
        for (int n = 0; n < 500; n++) begin
            if (n % 25 == 0) begin
                for (int k = 0; k < NCNT; k++) begin
                    if (k == 1) continue;
                    peek64(k, v);
                    checks++;
                    if (v !== m_cnt[k]) begin errors++; $display("FAIL rand_cnt%0d n=%0d got=%h exp=%h", k, n, v, m_cnt[k]); end
                end
            end
            a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : alist[$urandom_range(0, 27)];
            w = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       d = 32'hFFFF_FFFF;
                1:       d = 32'hFFFF_FFFE;
                2:       d = $urandom_range(0, 15);
                default: d = $urandom;
            endcase
            if (a == 12'h320) d = d & 32'h0000_0030;
            drive(w, a, d, 1'($urandom), EVENT_W'($urandom));
            model_read(w, a, erd, eill);
            checks++;
            if (rdata !== erd || illegal !== eill) begin
                errors++;
                $display("FAIL rand_read n=%0d addr=%h got=%h/%b exp=%h/%b", n, a, rdata, illegal, erd, eill);
            end
            checks++;
            if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf n=%0d got=%h exp=%h", n, ovf, m_ovf); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_split_write();
        test_wrap_ovf();
        test_event_count();
        test_inhibit();
        test_illegal();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
